// File: rtl/int_dispatch_pkg.sv
// Shared definitions for the interrupt dispatch sequencer: FSM encoding and
// the vector used when a dispatch is cancelled.
package int_dispatch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_PUSH_HI = 3'd2,
    ST_PUSH_LO = 3'd3,
    ST_JUMP    = 3'd4
  } state_t;

  localparam logic [15:0] CANCEL_VECTOR = 16'h0000;

endpackage

// File: rtl/int_dispatch.sv
// Interrupt dispatch sequencer: pushes PC onto the stack, jumps to the vector,
// and owns the master-enable (IME), delayed-EI and HALT bookkeeping.
module int_dispatch
  import int_dispatch_pkg::*;
#(
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clockgb,
  input  logic        resetn,
  input  logic        intreq,
  input  logic [15:0] intaddress,
  output logic        intack,
  input  logic        instr_boundary,
  input  logic        ei,
  input  logic        di,
  input  logic        reti,
  input  logic        halt_req,
  input  logic [15:0] pc,
  input  logic [15:0] sp,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_outdata,
  output logic        mem_store,
  output logic        sp_load,
  output logic [15:0] sp_next,
  output logic        pc_load,
  output logic [15:0] pc_next,
  output logic        busy,
  output logic        ime,
  output logic        halted
);

  localparam logic [1:0] WAIT_LAST = (WAIT_CYCLES > 0) ? 2'(WAIT_CYCLES - 1) : 2'd0;

  state_t      state, state_nx;
  logic [1:0]  wait_cnt, wait_cnt_nx;
  logic [15:0] vector, vector_nx;
  logic        ei_pending;
  logic        start;

  assign busy  = (state != ST_IDLE);
  assign start = (state == ST_IDLE) && instr_boundary && ime && intreq && !busy;

  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      wait_cnt <= 2'd0;
      vector   <= CANCEL_VECTOR;
    end else begin
      state    <= state_nx;
      wait_cnt <= wait_cnt_nx;
      vector   <= vector_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    wait_cnt_nx = wait_cnt;
    vector_nx   = vector;
    intack      = 1'b0;
    mem_address = 16'h0000;
    mem_outdata = 8'h00;
    mem_store   = 1'b0;
    sp_load     = 1'b0;
    sp_next     = 16'h0000;
    pc_load     = 1'b0;
    pc_next     = 16'h0000;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (WAIT_CYCLES == 0) begin
            state_nx = ST_PUSH_HI;
          end else begin
            state_nx    = ST_WAIT;
            wait_cnt_nx = WAIT_LAST;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 2'd0) state_nx = ST_PUSH_HI;
        else                  wait_cnt_nx = wait_cnt - 2'd1;
      end
      ST_PUSH_HI: begin
        // The vector is sampled here, so a request withdrawn during WAIT cancels.
        mem_address = sp - 16'd1;
        mem_outdata = pc[15:8];
        mem_store   = 1'b1;
        intack      = intreq;
        vector_nx   = intreq ? intaddress : CANCEL_VECTOR;
        state_nx    = ST_PUSH_LO;
      end
      ST_PUSH_LO: begin
        mem_address = sp - 16'd2;
        mem_outdata = pc[7:0];
        mem_store   = 1'b1;
        sp_load     = 1'b1;
        sp_next     = sp - 16'd2;
        state_nx    = ST_JUMP;
      end
      ST_JUMP: begin
        pc_load  = 1'b1;
        pc_next  = vector;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // IME / delayed EI / HALT: di beats everything, then dispatch start, then enables.
  always_ff @(posedge clockgb or negedge resetn) begin
    if (!resetn) begin
      ime        <= 1'b0;
      ei_pending <= 1'b0;
      halted     <= 1'b0;
    end else begin
      if (!busy && di) begin
        ime        <= 1'b0;
        ei_pending <= 1'b0;
      end else begin
        if (start) begin
          ime <= 1'b0;
        end else if (!busy && reti) begin
          ime <= 1'b1;
        end else if (ei_pending && instr_boundary) begin
          ime        <= 1'b1;
          ei_pending <= 1'b0;
        end
        if (!busy && ei) ei_pending <= 1'b1;
      end
      if (!busy && halt_req)    halted <= 1'b1;
      else if (halted && intreq) halted <= 1'b0;
    end
  end

endmodule

// File: doc/int_dispatch.md
INT_DISPATCH -- requirements
Module: int_dispatch

Interface
REQ-001 The block SHALL have parameter WAIT_CYCLES, default 2, meaning idle clockgb cycles between dispatch start and the first stack push (range 0..3).
REQ-002 The block SHALL have port clockgb input 1: the single system clock (one M-cycle per edge).
REQ-003 The block SHALL have port resetn input 1: asynchronous active-low reset.
REQ-004 The block SHALL have port intreq input 1: a pending enabled interrupt exists.
REQ-005 The block SHALL have port intaddress input 16: vector of the highest-priority pending interrupt.
REQ-006 The block SHALL have port intack output 1: one-cycle pulse that clears the serviced flag.
REQ-007 The block SHALL have port instr_boundary input 1: the CPU is at an instruction fetch boundary this cycle.
REQ-008 The block SHALL have ports ei, di, reti, halt_req, each input 1: one-cycle CPU command strobes.
REQ-009 The block SHALL have ports pc input 16 and sp input 16: current CPU registers.
REQ-010 The block SHALL have ports mem_address output 16, mem_outdata output 8 and mem_store output 1: the stack write bus.
REQ-011 The block SHALL have ports sp_load output 1 and sp_next output 16: stack-pointer update.
REQ-012 The block SHALL have ports pc_load output 1 and pc_next output 16: program-counter update.
REQ-013 The block SHALL have ports busy, ime and halted, each output 1: dispatch in progress, master enable, CPU halted.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT, PUSH_HI, PUSH_LO and JUMP, each lasting one cycle except WAIT, which lasts WAIT_CYCLES cycles and is skipped when WAIT_CYCLES=0.
REQ-015 IDLE->WAIT SHALL occur when instr_boundary && ime && intreq && !busy; on that edge ime SHALL clear and busy SHALL set.
REQ-016 In PUSH_HI: mem_address=sp-1, mem_outdata=pc[15:8], mem_store=1, intack=intreq, vector latched = intreq ? intaddress : 16'h0000.
REQ-017 In PUSH_LO: mem_address=sp-2, mem_outdata=pc[7:0], mem_store=1, sp_load=1, sp_next=sp-2.
REQ-018 In JUMP: pc_load=1, pc_next=latched vector; next state IDLE, busy clears.
REQ-019 intreq deasserted at PUSH_HI (cancelled dispatch) SHALL give intack=0 and jump to 16'h0000.
REQ-020 Stack address arithmetic SHALL be modulo 2^16 (sp=0x0001 -> pushes to 0x0000 and 0xFFFF, sp_next=0xFFFF).
REQ-021 di SHALL clear ime and any pending ei on the next edge.
REQ-022 ei SHALL set ei_pending; ime SHALL set at the edge after the next instr_boundary following the ei cycle, so no dispatch occurs at that boundary.
REQ-023 reti SHALL set ime on the next edge with no delay.
REQ-024 When di and ei are strobed in the same cycle, di SHALL win.
REQ-025 halt_req SHALL set halted; halted SHALL clear the cycle after intreq is seen, regardless of ime.
REQ-026 Waking with ime=1 SHALL start dispatch at the next instr_boundary; waking with ime=0 SHALL resume without dispatch.
REQ-027 ei, di, reti and halt_req arriving while busy SHALL be ignored.
REQ-028 All of mem_store, sp_load, pc_load and intack SHALL be 0 outside their own states.

Reset
REQ-029 resetn low SHALL asynchronously force: state IDLE, ime=0, ei_pending=0, halted=0, busy=0, intack=0, mem_store=0, sp_load=0, pc_load=0, and all data outputs 0.
REQ-030 Reset asserted mid-dispatch SHALL abort with no further store, load or ack.

Structure
REQ-031 The FSM state encoding and the cancelled-dispatch vector 16'h0000 SHALL be defined in the shared gb package.
REQ-032 The block SHALL be a single module with no sub-modules; IME/EI-delay logic and the FSM SHALL live in separate always blocks.

Verification
REQ-033 Basic dispatch: ime=1, pc=0x1234, sp=0xFFFE, intreq=1, intaddress=0x0050 at boundary -> writes 0x12@0xFFFD and 0x34@0xFFFC, sp_next=0xFFFC, pc_next=0x0050, a single intack pulse, ime=0.
REQ-034 EI delay: ei, then boundary with intreq=1 -> no dispatch; dispatch starts at the second boundary.
REQ-035 Cancellation: intreq drops during WAIT -> intack never pulses, pc_next=0x0000, both pushes still occur.
REQ-036 HALT with ime=0: halt_req, then intreq=1 -> halted clears next cycle, no mem_store occurs.
REQ-037 Wrap: sp=0x0001 -> pushes to 0x0000 and 0xFFFF, sp_next=0xFFFF.
REQ-038 Reset asserted during PUSH_LO -> all strobes are 0 immediately, state IDLE, ime=0.
